// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : shared arbitration mode encodings and index-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin / fixed-priority one-hot arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    input  logic              mode_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   grant_idx_o,
    output logic [CH_W-1:0]   next_ptr_o
);

    localparam logic [CH_W:0]   C_NUM  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_cand;

    // Scan from farthest to nearest candidate so the nearest valid one wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mode_i == MODE_FIXED) begin
                w_sum = (CH_W+1)'(k);
            end else begin
                w_sum = {1'b0, ptr_i} + (CH_W+1)'(k);
                if (w_sum >= C_NUM) begin
                    w_sum = w_sum - C_NUM;
                end
            end
            w_cand = w_sum[CH_W-1:0];
            if (en_i && req_i[w_cand]) begin
                grant_o         = '0;
                grant_o[w_cand] = 1'b1;
                grant_idx_o     = w_cand;
            end
        end
    end

    always_comb begin
        next_ptr_o = ptr_i;
        if ((mode_i == MODE_RR) && (|grant_o)) begin
            if (grant_idx_o == C_LAST) begin
                next_ptr_o = '0;
            end else begin
                next_ptr_o = grant_idx_o + CH_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// ============================================================================
// rr_arb_mux : N-channel arbitrated valid/ready mux with registered output
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb_mux
    import arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [CH_W-1:0]   rr_ptr_q,    rr_ptr_d;

    logic              w_load_en;
    logic              w_arb_en;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_grant_idx;
    logic [CH_W-1:0]   w_next_ptr;
    logic [DATA_W-1:0] w_win_data;

    // Gating with rst_n keeps in_ready low for the whole reset window.
    assign w_load_en = ~out_valid_q | out_ready;
    assign w_arb_en  = w_load_en & rst_n;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .req_i       (in_valid),
        .ptr_i       (rr_ptr_q),
        .mode_i      (mode),
        .en_i        (w_arb_en),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .next_ptr_o  (w_next_ptr)
    );

    assign in_ready = w_grant;
    assign w_xfer   = |w_grant;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_win_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_win_data;
            out_ch_d    = w_grant_idx;
            rr_ptr_d    = w_next_ptr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// tb_rr_arb_mux : directed and randomized checks of rr_arb_mux
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb_mux;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 2;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            mode      = 1'b0;
    logic            out_ready = 1'b0;
    logic [N-1:0]    in_valid  = '0;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ch;
    logic [DW-1:0]   ch_data [N];

    int total = 0;
    int bad   = 0;

    // Reference state: contents of the output stage and the round-robin start.
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;

    rr_arb_mux #(.DATA_W(DW), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = ch_data[i];
    end

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int c;
            c = mode ? k : (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int p;
        r = '0;
        p = pick();
        if (rst_n && (!m_valid || out_ready) && p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
    endtask

    // One clock: predict from current inputs, advance at the edge, return at negedge.
    task automatic tick();
        int   p;
        logic load;
        p    = pick();
        load = !m_valid || out_ready;
        @(posedge clk);
        if (load && p >= 0) begin
            m_valid = 1; m_data = ch_data[p]; m_ch = p;
            if (!mode) m_ptr = (p + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic set_tags();
        for (int i = 0; i < N; i++) ch_data[i] = 32'hA0 + i;
    endtask

    task automatic test_reset();
        set_tags();
        in_valid = '1; out_ready = 1'b1; mode = 1'b0; rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        if (out_ch !== '0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        if (in_ready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
        model_reset();
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL release_ready got=%b exp=0001", in_ready); end
        tick();
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", out_valid); end
        if (out_ch !== 2'd0) begin bad++; $display("FAIL release_ch got=%0d exp=0", out_ch); end
        if (out_data !== 32'hA0) begin bad++; $display("FAIL release_data got=%h exp=a0", out_data); end
    endtask

    task automatic test_rr_fairness();
        set_tags();
        mode = 1'b0; out_ready = 1'b1; in_valid = '1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            total += 2;
            if (out_ch !== CW'(i % N)) begin bad++; $display("FAIL rr_ch step=%0d got=%0d exp=%0d", i, out_ch, i % N); end
            if (out_data !== 32'hA0 + 32'(i % N)) begin
                bad++; $display("FAIL rr_data step=%0d got=%h exp=%h", i, out_data, 32'hA0 + 32'(i % N));
            end
        end
    endtask

    task automatic test_fixed();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0010) begin bad++; $display("FAIL fixed_ready step=%0d got=%b exp=0010", i, in_ready); end
            tick();
            total += 2;
            if (out_ch !== 2'd1) begin bad++; $display("FAIL fixed_ch step=%0d got=%0d exp=1", i, out_ch); end
            if (out_data !== 32'hA1) begin bad++; $display("FAIL fixed_data step=%0d got=%h exp=a1", i, out_data); end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; out_ready = 1'b1;
        ch_data[1] = 32'h1234; ch_data[2] = 32'hB2; ch_data[0] = 32'hB0;
        in_valid = 4'b0010;
        tick();
        out_ready = 1'b0; in_valid = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            #1;
            total += 3;
            if (in_ready !== '0) begin bad++; $display("FAIL bp_ready step=%0d got=%b exp=0000", i, in_ready); end
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid step=%0d got=%b exp=1", i, out_valid); end
            if (out_data !== 32'h1234) begin bad++; $display("FAIL bp_data step=%0d got=%h exp=1234", i, out_data); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        tick();
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_nobubble got=%b exp=1", out_valid); end
        if (out_ch !== 2'd2) begin bad++; $display("FAIL bp_ch got=%0d exp=2", out_ch); end
        if (out_data !== 32'hB2) begin bad++; $display("FAIL bp_data2 got=%h exp=b2", out_data); end
    endtask

    task automatic test_sparse_wrap();
        set_tags();
        mode = 1'b0; out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0001;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin bad++; $display("FAIL wrap_ready got=%b exp=0001", in_ready); end
        tick();
        total++;
        if (out_ch !== 2'd0) begin bad++; $display("FAIL wrap_ch got=%0d exp=0", out_ch); end
        in_valid = '0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        in_valid = '1;
        #1;
        total++;
        if (in_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ptr got=%b exp=0010", in_ready); end
        tick();
    endtask

    task automatic test_async_reset();
        set_tags();
        mode = 1'b0; out_ready = 1'b1; in_valid = '1;
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        if (out_data !== '0) begin bad++; $display("FAIL ar_data got=%h exp=0", out_data); end
        if (in_ready !== '0) begin bad++; $display("FAIL ar_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        tick();
        total += 2;
        if (out_ch !== 2'd0) begin bad++; $display("FAIL ar_restart_ch got=%0d exp=0", out_ch); end
        if (out_data !== 32'hA0) begin bad++; $display("FAIL ar_restart_data got=%h exp=a0", out_data); end
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        logic [N-1:0] er;
        acc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !acc[i])) ch_data[i] = $urandom;
            end
            in_valid  = (in_valid & ~acc) | N'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            #1;
            er = exp_ready();
            total += 2;
            if (in_ready !== er) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, er); end
            if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid); end
            if (m_valid) begin
                total += 2;
                if (out_data !== m_data) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, out_data, m_data); end
                if (out_ch !== CW'(m_ch)) begin bad++; $display("FAIL rnd_ch cyc=%0d got=%0d exp=%0d", cyc, out_ch, m_ch); end
            end
            acc = er;
            tick();
        end
    endtask

    initial begin
        model_reset();
        set_tags();
        @(negedge clk);
        test_reset();
        test_rr_fairness();
        test_fixed();
        test_backpressure();
        test_sparse_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated multiplexer that succeeds the fixed 4:1 select mux in the datapath.
- Selects one of NUM_CH valid/ready input streams by round-robin or fixed priority, not by an external select.
- Registers the winner into a single output stage and reports which channel it came from.
- Used wherever several producers share one consumer, e.g. writeback-port or memory-request sharing.

Parameters:
DATA_W  32  width of each data channel in bits
NUM_CH  4  number of input channels, 1 to 16
CH_W  $clog2(NUM_CH), minimum 1  width of channel index (derived, do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
in_valid  input  NUM_CH  per-channel request valid
in_ready  output  NUM_CH  per-channel accept; combinational
in_data  input  NUM_CH*DATA_W  packed channel data; channel i at bits [i*DATA_W +: DATA_W]
out_valid  output  1  output register holds a transfer
out_ready  input  1  consumer accept
out_data  output  DATA_W  registered winning data
out_ch  output  CH_W  registered index of winning channel

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is all-zero while rst_n is low.
- load_en = ~out_valid | out_ready. The output stage can accept a new word when it is empty or being drained this cycle.
- Grant (combinational, one-hot, at most one bit set):
  - mode=1: lowest-index valid channel.
  - mode=0: first valid channel scanning rr_ptr, rr_ptr+1, … with wrap-around modulo NUM_CH.
  - No valid inputs: grant=0.
- in_ready[i] = grant[i] & load_en. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer at a rising edge:
  - out_data <= in_data[granted]
  - out_ch <= granted index
  - out_valid <= 1
  - if mode=0, rr_ptr <= granted+1, wrapping NUM_CH-1 -> 0
  - if mode=1, rr_ptr is unchanged
- No transfer and out_ready=1: out_valid <= 0. out_data and out_ch hold their last values.
- out_valid=1 and out_ready=0: out_data, out_ch, out_valid and rr_ptr are all held stable; no in_ready asserted.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: one word per cycle while out_ready=1. Simultaneous drain and reload in the same cycle is required, with no bubble.
- Producers must not make in_valid depend on in_ready. Once asserted, in_valid stays high until accepted; the block does not check this.
- Fairness (mode=0): with all channels continuously valid, grants cycle 0,1,…,NUM_CH-1,0 exactly.
- A channel that was granted but not accepted, because of backpressure, gets no pointer advance.
- Mode change takes effect on the next grant evaluation. rr_ptr is retained across mode changes.
- NUM_CH=1: grant[0]=in_valid[0], out_ch constant 0, rr_ptr stays 0.
- rst_n asserted mid-transfer: the pending output word is discarded with no handshake completion.

Decomposition:
- Package arb_pkg:
  - MODE_RR=1'b0, MODE_FIXED=1'b1
  - function clog2_min1 for CH_W
- Sub-module rr_arbiter (params NUM_CH):
  - inputs req, ptr, mode, en
  - outputs one-hot grant, encoded grant_idx, next_ptr
  - purely combinational, reused by future arbitrated blocks
- Top level holds the output register and rr_ptr.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0; release -> first accepted is ch0, out_valid=1 one cycle later.
- Round-robin fairness: NUM_CH=4, mode=0, all valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles with out_data matching each channel's tag (0xA0..0xA3).
- Fixed priority: mode=1, ch1 and ch3 valid continuously -> out_ch=1 every cycle, in_ready[3] never asserted.
- Backpressure: out_valid=1 with data 0x1234, out_ready=0 for 5 cycles while ch2 valid -> out_data stays 0x1234, in_ready=0, rr_ptr unchanged; out_ready=1 -> ch2 loaded the same edge, no bubble.
- Sparse/wrap: mode=0, rr_ptr=3, only ch0 valid -> grant ch0, rr_ptr becomes 1; no valid inputs with out_ready=1 -> out_valid falls to 0 next cycle.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid=0 immediately; after release, arbitration restarts at ch0.
